// File: rtl/mdu_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mdu_issue                                                  |
// | Description : Multicycle issue/hold controller for the combinational     |
// |               multiply/divide unit. Accepts one M-extension op, holds    |
// |               the operands steady on the MDU inputs for MUL_CYCLES or    |
// |               DIV_CYCLES cycles, then captures the result and offers it  |
// |               to writeback over a valid/ready handshake.                 |
// | Options     : `define MDU_DIV_FIXUP_EN to resolve RISC-V divide-by-zero  |
// |               and signed-overflow cases locally (one-cycle latency,      |
// |               MDU result ignored for those cases).                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mdu_issue #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_rd,
  output logic [31:0] mdu_rs1,
  output logic [31:0] mdu_src2,
  output logic [2:0]  mdu_control,
  input  logic [31:0] mdu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        busy
);

  // Counter reload values: the counter reaches zero on the edge before capture.
  localparam logic [3:0] c_mul_load = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] c_div_load = 4'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] src2_q, src2_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  w_load;

`ifdef MDU_DIV_FIXUP_EN
  // A pending fixup result is parked in res_q at accept; the capture edge
  // then keeps it instead of sampling the (possibly unsettled) MDU output.
  logic        fix_q, fix_d;
  logic        w_div0;
  logic        w_ovf;
  logic [31:0] w_fix_val;

  // Classify the incoming op as a RISC-V divide special case.
  always_comb begin
    w_div0    = in_op[2] && (in_rs2 == 32'h0000_0000);
    w_ovf     = in_op[2] && !in_op[0] &&
                (in_rs1 == 32'h8000_0000) && (in_rs2 == 32'hFFFF_FFFF);
    w_fix_val = 32'h0000_0000;
    if (w_div0) begin
      // REM/REMU return the dividend, DIV/DIVU return all ones.
      w_fix_val = in_op[1] ? in_rs1 : 32'hFFFF_FFFF;
    end else if (w_ovf) begin
      // DIV returns the most negative value, REM returns zero.
      w_fix_val = in_op[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end
`endif

  assign w_load = in_op[2] ? c_div_load : c_mul_load;

  // State and datapath registers; async reset clears everything visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rs1_q   <= 32'h0000_0000;
      src2_q  <= 32'h0000_0000;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      res_q   <= 32'h0000_0000;
`ifdef MDU_DIV_FIXUP_EN
      fix_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs1_q   <= rs1_d;
      src2_q  <= src2_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
`ifdef MDU_DIV_FIXUP_EN
      fix_q   <= fix_d;
`endif
    end
  end

  // Next-state and datapath update; flush overrides both handshakes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs1_d   = rs1_q;
    src2_d  = src2_q;
    op_d    = op_q;
    rd_d    = rd_q;
    res_d   = res_q;
`ifdef MDU_DIV_FIXUP_EN
    fix_d   = fix_q;
`endif
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            rs1_d   = in_rs1;
            src2_d  = in_rs2;
            op_d    = in_op;
            rd_d    = in_rd;
            cnt_d   = w_load;
            state_d = ST_WAIT;
`ifdef MDU_DIV_FIXUP_EN
            fix_d = w_div0 || w_ovf;
            if (w_div0 || w_ovf) begin
              // Capture on the very next edge using the local result.
              cnt_d = 4'd0;
              res_d = w_fix_val;
            end
`endif
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = ST_DONE;
`ifdef MDU_DIV_FIXUP_EN
            if (!fix_q) begin
              res_d = mdu_result;
            end
`else
            res_d = mdu_result;
`endif
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign out_result  = res_q;
  assign out_rd      = rd_q;
  assign mdu_rs1     = rs1_q;
  assign mdu_src2    = src2_q;
  assign mdu_control = op_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mdu_issue                                               |
// | Description : Self-checking bench for mdu_issue. Contains a behavioural  |
// |               MDU whose output is garbage until its inputs have been     |
// |               stable long enough, plus a transaction-level model that is |
// |               compared against the DUT after every clock edge.           |
// | Options     : honours `define MDU_DIV_FIXUP_EN like the design.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mdu_issue;

  localparam int MUL_C = 2;
  localparam int DIV_C = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;
  logic [31:0] mdu_rs1;
  logic [31:0] mdu_src2;
  logic [2:0]  mdu_control;
  logic [31:0] mdu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  mdu_issue #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .mdu_rs1(mdu_rs1), .mdu_src2(mdu_src2), .mdu_control(mdu_control),
    .mdu_result(mdu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // RISC-V M-extension reference arithmetic.
  function automatic logic [31:0] golden(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    logic signed [31:0] q;
    logic [31:0]        r;
    r = 32'h0;
    case (op)
      3'd0: begin pu = {32'h0, a} * {32'h0, b}; r = pu[31:0]; end
      3'd1: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = ps[63:32]; end
      3'd2: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'h0, b}); r = ps[63:32]; end
      3'd3: begin pu = {32'h0, a} * {32'h0, b}; r = pu[63:32]; end
      3'd4: begin
        if (b == 32'h0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin q = $signed(a) / $signed(b); r = q; end
      end
      3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin q = $signed(a) % $signed(b); r = q; end
      end
      default: r = (b == 32'h0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    return op[2] ? DIV_C : MUL_C;
  endfunction

  // Behavioural MDU: only gives the right answer once its inputs have been
  // stable for the full hold time, so an early capture shows up as garbage.
  int          stab = 0;
  logic [66:0] prev_mdu = 'x;
  always @(posedge clk) begin
    #1;
    if ({mdu_rs1, mdu_src2, mdu_control} !== prev_mdu) stab = 0;
    else if (stab < 1000) stab = stab + 1;
    prev_mdu = {mdu_rs1, mdu_src2, mdu_control};
  end
  assign mdu_result = (stab >= lat_of(mdu_control) - 1) ?
                      golden(mdu_control, mdu_rs1, mdu_src2) : 32'hBAD0_0BAD;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: busy flag, cycles remaining, result when done.
  bit          m_busy = 0;
  bit          m_ov   = 0;
  int          m_left = 0;
  logic [31:0] m_res  = 0;
  logic [31:0] m_a    = 0;
  logic [31:0] m_b    = 0;
  logic [2:0]  m_op   = 0;
  logic [4:0]  m_rd   = 0;

  function automatic bit special(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef MDU_DIV_FIXUP_EN
    return op[2] && (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model each edge, then compare the DUT against it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_ov = 0; m_left = 0; m_res = 0;
      m_a = 0; m_b = 0; m_op = 0; m_rd = 0;
    end else begin
      cyc = cyc + 1;
      if (flush) begin
        m_busy = 0; m_ov = 0;
      end else if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1; m_a = in_rs1; m_b = in_rs2; m_op = in_op; m_rd = in_rd;
          m_left = special(in_op, in_rs1, in_rs2) ? 1 : lat_of(in_op);
        end
      end else if (m_ov) begin
        if (out_ready) begin m_busy = 0; m_ov = 0; end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_ov = 1; m_res = golden(m_op, m_a, m_b); end
      end
    end
    #1;
    chk("in_ready", in_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, m_ov);
    chk("out_rd", out_rd, m_rd);
    chk("mdu_rs1", mdu_rs1, m_a);
    chk("mdu_src2", mdu_src2, m_b);
    chk("mdu_control", mdu_control, m_op);
    if (m_ov) chk("out_result", out_result, m_res);
  end

  // Issue one op, wait for the result, check literal expectations, then retire it.
  task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int exp_lat, input int hold);
    int acc;
    int n;
    @(negedge clk);
    in_valid = 1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
    out_ready = (hold == 0);
    @(posedge clk); #2;
    acc = cyc;
    @(negedge clk);
    in_valid = 0; in_rs1 = $urandom; in_rs2 = $urandom; in_rd = 5'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n = n + 1; end
    chk({nm, " valid_seen"}, out_valid, 1);
    chk({nm, " latency"}, 64'(cyc - acc), 64'(exp_lat));
    chk({nm, " result"}, out_result, exp);
    chk({nm, " rd"}, out_rd, rd);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({nm, " held_ready"}, in_ready, 0);
      chk({nm, " held_result"}, out_result, exp);
      out_ready = 1;
    end
    @(negedge clk);
    chk({nm, " retired"}, in_ready, 1);
  endtask

  initial begin
    int n;
`ifdef MDU_DIV_FIXUP_EN
    int fl = 1;
`else
    int fl = DIV_C;
`endif
    rst_n = 0; flush = 0; in_valid = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0;
    in_rd = 0; out_ready = 1;
    #3;
    chk("rst in_ready", in_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_result", out_result, 0);
    chk("rst mdu", {mdu_rs1, mdu_src2, mdu_control, out_rd}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    issue("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MUL_C, 0);
    issue("divu_hold", 3'd5, 32'd100, 32'd7, 5'd9, 32'd14, DIV_C, 5);
    issue("div_by0", 3'd4, 32'd5, 32'd0, 5'd3, 32'hFFFF_FFFF, fl, 0);
    issue("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, fl, 0);
    issue("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h0, fl, 0);
    issue("remu_by0", 3'd7, 32'd17, 32'd0, 5'd8, 32'd17, fl, 0);
    issue("mulh", 3'd1, 32'h8000_0000, 32'd2, 5'd10, 32'hFFFF_FFFF, MUL_C, 0);
    issue("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFF, MUL_C, 0);
    issue("remu", 3'd7, 32'd17, 32'd5, 5'd12, 32'd2, DIV_C, 2);
    issue("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFD, DIV_C, 0);

    // Flush in WAIT once the counter has counted down to 3.
    @(negedge clk);
    in_valid = 1; in_op = 3'd4; in_rs1 = 32'd1000; in_rs2 = 32'd10; in_rd = 5'd14;
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush in_ready", in_ready, 1);
    chk("flush busy", busy, 0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) n = n + 1;
    end
    chk("flush no_valid", 64'(n), 0);
    issue("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE, MUL_C, 0);

    // Asynchronous reset while holding a result in DONE.
    @(negedge clk);
    in_valid = 1; in_op = 3'd0; in_rs1 = 32'd3; in_rs2 = 32'd4; in_rd = 5'd7;
    out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n = n + 1; end
    chk("pre_rst valid", out_valid, 1);
    chk("pre_rst result", out_result, 32'd12);
    #2;
    rst_n = 0;
    #1;
    chk("arst out_valid", out_valid, 0);
    chk("arst in_ready", in_ready, 1);
    chk("arst busy", busy, 0);
    chk("arst data", {out_result, out_rd, mdu_rs1, mdu_src2, mdu_control}, 0);
    @(negedge clk);
    rst_n = 1;
    issue("post_rst", 3'd0, 32'd6, 32'd9, 5'd1, 32'd54, MUL_C, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mdu_issue.md
# mdu_issue

Multicycle issue/hold controller placed directly upstream of the combinational multiply/divide unit (MDU). It accepts one M-extension operation at a time from the execute stage over a valid/ready handshake. It latches the operands and holds them steady on the MDU inputs for a programmable number of cycles, so the MDU can be constrained as a multicycle path. It then captures the MDU result and presents it, tagged with its destination register, to writeback over a second valid/ready handshake.

## Interface
Parameters:
- MUL_CYCLES, 2: hold cycles for op[2]=0 (MUL/MULH/MULHSU/MULHU); legal range 1..15
- DIV_CYCLES, 8: hold cycles for op[2]=1 (DIV/DIVU/REM/REMU); legal range 1..15

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of any in-flight operation
- in_valid  input  1  request valid
- in_ready  output  1  block can accept; equals (state==IDLE)
- in_op  input  3  MDU encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_rs1  input  32  operand 1
- in_rs2  input  32  operand 2
- in_rd  input  5  destination tag
- mdu_rs1  output  32  latched operand 1 to MDU
- mdu_src2  output  32  latched operand 2 to MDU
- mdu_control  output  3  latched op to MDU
- mdu_result  input  32  MDU combinational result
- out_valid  output  1  result valid
- out_ready  input  1  writeback accepts
- out_result  output  32  captured result
- out_rd  output  5  tag of captured result
- busy  output  1  state != IDLE

## Operation
- States: IDLE, WAIT, DONE. Reset enters IDLE.
- IDLE: accept on in_valid & in_ready & !flush.
  - Latch in_rs1, in_rs2, in_op and in_rd into mdu_rs1, mdu_src2, mdu_control and out_rd.
  - Load the 4-bit counter with (in_op[2] ? DIV_CYCLES : MUL_CYCLES) - 1.
  - Go to WAIT.
- WAIT: at each edge, if the counter is 0, capture mdu_result into out_result and go to DONE; otherwise decrement the counter.
- DONE: out_valid=1. On out_ready, go to IDLE.
- mdu_* outputs hold their latched values through WAIT and DONE. They are not cleared on return to IDLE; they change only on the next accept.
- out_result and out_rd are stable while out_valid & !out_ready.
- flush: in any state, the next state is IDLE and out_valid drops at the next edge. flush takes priority over accept and over the out handshake. A flushed result is never delivered.
- No bypass: in_ready is low in DONE even when out_ready is high.

## Timing
- Reset values:
  - in_ready=1, busy=0, out_valid=0.
  - out_result, out_rd, mdu_rs1, mdu_src2, mdu_control all 0.
  - Counter 0.
- Latency, with L the selected cycle count and the accept at edge 0:
  - Result captured at edge L; out_valid is high from edge L.
  - With out_ready held high, the out handshake completes at edge L+1, and the next accept is possible at edge L+2.
  - Peak throughput is one op per L+2 cycles.
- mdu_result is sampled only at the capture edge, after at least L full cycles of stable mdu_* inputs.
- Reset asserted mid-operation: outputs immediately (asynchronously) take their reset values; the operation is lost.

## Configuration
- MDU_DIV_FIXUP_EN defined: at accept, the block detects RISC-V special cases and goes straight to DONE with a locally generated result. out_valid is then high from edge 1.
  - Divide by zero (in_rs2==0):
    - DIV 0xFFFFFFFF
    - DIVU 0xFFFFFFFF
    - REM in_rs1
    - REMU in_rs1
  - Signed overflow (in_rs1==0x80000000 and in_rs2==0xFFFFFFFF):
    - DIV 0x80000000
    - REM 0
  - The MDU result is ignored for these cases.
- MDU_DIV_FIXUP_EN undefined: no detection. All ops take the full latency and return whatever the MDU produces.

## Test plan
- MUL 7 × -3 (0xFFFFFFFD), rd=5, MUL_CYCLES=2, out_ready=1 -> out_valid high from edge 2, out_result 0xFFFFFFEB, out_rd 5, in_ready back after edge 3.
- DIVU 100/7, DIV_CYCLES=8, out_ready=0 for 5 cycles after out_valid -> result 14 held stable, in_ready stays 0 until the handshake.
- DIV 5/0 with MDU_DIV_FIXUP_EN -> out_valid from edge 1, result 0xFFFFFFFF. Without the macro -> valid from edge 8, result equals mdu_result.
- DIV 0x80000000/0xFFFFFFFF with fixup -> 0x80000000; REM with the same operands -> 0.
- flush asserted in WAIT with counter at 3 -> IDLE next edge, out_valid never rises. A new MULHU 0xFFFFFFFF×0xFFFFFFFF is then accepted -> 0xFFFFFFFE.
- rst_n pulsed low in DONE -> out_valid=0, in_ready=1, all data outputs 0 immediately.
